// File: rtl/comp_mult_acc.sv
// Pipelined complex multiply-accumulate.
// Four register stages: input capture, partial products, complex sum,
// then accumulate / round / narrow into the output register.
// Each frame closes after ACC_LEN valid samples, or early on i_last.
module comp_mult_acc #(
    parameter int INPUT_WIDTH_I  = 4,
    parameter int INPUT_WIDTH_II = 4,
    parameter int OUTPUT_WIDTH   = 8,
    parameter int ACC_LEN        = 4,
    parameter int SHIFT          = 0,
    parameter int WRAP_SATURATE  = 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst_p,
    input  logic signed [INPUT_WIDTH_I-1:0]   i_a,
    input  logic signed [INPUT_WIDTH_I-1:0]   i_b,
    input  logic signed [INPUT_WIDTH_II-1:0]  i_c,
    input  logic signed [INPUT_WIDTH_II-1:0]  i_d,
    input  logic                              i_valid_data,
    input  logic                              i_conj,
    input  logic                              i_last,
    output logic signed [OUTPUT_WIDTH-1:0]    o_r,
    output logic signed [OUTPUT_WIDTH-1:0]    o_im,
    output logic                              o_valid_data,
    output logic                              o_ovf
);

    // Product, complex-sum and accumulator widths; the accumulator carries
    // enough headroom that a full frame can never overflow internally.
    localparam int PW = INPUT_WIDTH_I + INPUT_WIDTH_II;
    localparam int SW = PW + 1;
    localparam int AW = SW + $clog2(ACC_LEN) + 1;
    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    // Width used for rounding and range comparison: one bit above the
    // accumulator so the rounding offset cannot overflow, and never narrower
    // than the output.
    localparam int EW = (AW + 1 > OUTPUT_WIDTH) ? AW + 1 : OUTPUT_WIDTH;

    localparam logic [CW-1:0]        LAST_CNT = CW'(ACC_LEN - 1);
    localparam logic signed [EW-1:0] HALF     = (EW'(1) << SHIFT) >> 1;
    localparam logic signed [EW-1:0] MAX_V    = {{(EW-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V    = {{(EW-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

    // Round half up, then arithmetic shift; HALF is zero when SHIFT is zero.
    function automatic logic signed [EW-1:0] round_shift(input logic signed [AW-1:0] v);
        logic signed [EW-1:0] t;
        t = EW'(v);
        t = (t + HALF) >>> SHIFT;
        return t;
    endfunction

    function automatic logic out_of_range(input logic signed [EW-1:0] v);
        return (v > MAX_V) || (v < MIN_V);
    endfunction

    // Saturate to the nearest bound or drop the upper bits.
    function automatic logic signed [OUTPUT_WIDTH-1:0] narrow(input logic signed [EW-1:0] v);
        if ((WRAP_SATURATE != 0) && (v > MAX_V)) begin
            return MAX_V[OUTPUT_WIDTH-1:0];
        end else if ((WRAP_SATURATE != 0) && (v < MIN_V)) begin
            return MIN_V[OUTPUT_WIDTH-1:0];
        end else begin
            return v[OUTPUT_WIDTH-1:0];
        end
    endfunction

    logic signed [INPUT_WIDTH_I-1:0]  a_p1, b_p1;
    logic signed [INPUT_WIDTH_II-1:0] c_p1, d_p1;
    logic                             conj_p1, last_p1, vld_p1;

    logic signed [PW-1:0] ac_p2, bd_p2, ad_p2, bc_p2;
    logic                 conj_p2, last_p2, vld_p2;

    logic signed [SW-1:0] re_p3, im_p3;
    logic                 last_p3, vld_p3;

    logic signed [AW-1:0] acc_re, acc_im;
    logic [CW-1:0]        cnt;

    logic signed [AW-1:0] sum_re, sum_im;
    logic signed [EW-1:0] rnd_re, rnd_im;
    logic                 close;

    // S1: capture operands and sideband; only the valid flag is reset
    always_ff @(posedge i_clk) begin
        a_p1    <= i_a;
        b_p1    <= i_b;
        c_p1    <= i_c;
        d_p1    <= i_d;
        conj_p1 <= i_conj;
        last_p1 <= i_last;
        if (i_rst_p) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= i_valid_data;
        end
    end

    // S2: the four full-width partial products
    always_ff @(posedge i_clk) begin
        ac_p2   <= PW'(a_p1) * PW'(c_p1);
        bd_p2   <= PW'(b_p1) * PW'(d_p1);
        ad_p2   <= PW'(a_p1) * PW'(d_p1);
        bc_p2   <= PW'(b_p1) * PW'(c_p1);
        conj_p2 <= conj_p1;
        last_p2 <= last_p1;
        if (i_rst_p) begin
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
        end
    end

    // S3: complex sum, with the conjugate form selected by conj
    always_ff @(posedge i_clk) begin
        if (conj_p2) begin
            re_p3 <= SW'(ac_p2) + SW'(bd_p2);
            im_p3 <= SW'(bc_p2) - SW'(ad_p2);
        end else begin
            re_p3 <= SW'(ac_p2) - SW'(bd_p2);
            im_p3 <= SW'(ad_p2) + SW'(bc_p2);
        end
        last_p3 <= last_p2;
        if (i_rst_p) begin
            vld_p3 <= 1'b0;
        end else begin
            vld_p3 <= vld_p2;
        end
    end

    // S4 combinational: running sum (restarting on the first sample of a frame) and its rounded form
    always_comb begin
        sum_re = (cnt == '0) ? AW'(re_p3) : acc_re + AW'(re_p3);
        sum_im = (cnt == '0) ? AW'(im_p3) : acc_im + AW'(im_p3);
        close  = (cnt == LAST_CNT) || last_p3;
        rnd_re = round_shift(sum_re);
        rnd_im = round_shift(sum_im);
    end

    // S4 register: accumulate, or emit the narrowed frame result and restart
    always_ff @(posedge i_clk) begin
        if (i_rst_p) begin
            acc_re       <= '0;
            acc_im       <= '0;
            cnt          <= '0;
            o_r          <= '0;
            o_im         <= '0;
            o_valid_data <= 1'b0;
            o_ovf        <= 1'b0;
        end else begin
            o_valid_data <= 1'b0;
            if (vld_p3) begin
                if (close) begin
                    o_r          <= narrow(rnd_re);
                    o_im         <= narrow(rnd_im);
                    o_ovf        <= out_of_range(rnd_re) || out_of_range(rnd_im);
                    o_valid_data <= 1'b1;
                    acc_re       <= '0;
                    acc_im       <= '0;
                    cnt          <= '0;
                end else begin
                    acc_re <= sum_re;
                    acc_im <= sum_im;
                    cnt    <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_comp_mult_acc.sv
// Bench for comp_mult_acc: four configurations share one stimulus stream.
//   0: ACC_LEN=4 SHIFT=0 saturate   1: ACC_LEN=1 SHIFT=0 saturate
//   2: ACC_LEN=4 SHIFT=0 wrap       3: ACC_LEN=1 SHIFT=2 saturate
// A sample-level model predicts every output each cycle; directed tests
// add literal expectations on top.
module tb_comp_mult_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic signed [3:0] a, b, c, d;
    logic              vld, conj, last;

    logic signed [7:0] o_r  [4];
    logic signed [7:0] o_im [4];
    logic              o_vld [4];
    logic              o_ovf [4];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        comp_mult_acc #(
            .INPUT_WIDTH_I (4),
            .INPUT_WIDTH_II(4),
            .OUTPUT_WIDTH  (8),
            .ACC_LEN       ((g == 1 || g == 3) ? 1 : 4),
            .SHIFT         ((g == 3) ? 2 : 0),
            .WRAP_SATURATE ((g == 2) ? 0 : 1)
        ) u_dut (
            .i_clk       (clk),
            .i_rst_p     (rst),
            .i_a         (a),
            .i_b         (b),
            .i_c         (c),
            .i_d         (d),
            .i_valid_data(vld),
            .i_conj      (conj),
            .i_last      (last),
            .o_r         (o_r[g]),
            .o_im        (o_im[g]),
            .o_valid_data(o_vld[g]),
            .o_ovf       (o_ovf[g])
        );
    end

    function automatic int acc_len(int k);
        return (k == 1 || k == 3) ? 1 : 4;
    endfunction

    function automatic int shift_of(int k);
        return (k == 3) ? 2 : 0;
    endfunction

    function automatic bit sat_of(int k);
        return (k != 2);
    endfunction

    // Round half up, shift, then saturate or wrap into signed 8 bits.
    function automatic int narrow_m(int k, int v, output bit ovf);
        int x;
        x   = (v + ((1 << shift_of(k)) >> 1)) >>> shift_of(k);
        ovf = (x > 127) || (x < -128);
        if (ovf) begin
            if (sat_of(k)) begin
                x = (x > 127) ? 127 : -128;
            end else begin
                x = x & 255;
                if (x > 127) x = x - 256;
            end
        end
        return x;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int re;
        int im;
        bit last;
        int due;
    } smp_t;

    smp_t q[$];
    smp_t cur;
    int   cyc = 0;
    bit   model_ok = 0;
    int   m_acc_re [4];
    int   m_acc_im [4];
    int   m_cnt    [4];
    int   exp_r    [4];
    int   exp_im   [4];
    bit   exp_ovf  [4];
    bit   exp_vld  [4];
    bit   ov_r, ov_i;
    int   ia, ib, ic, id;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            for (int k = 0; k < 4; k++) begin
                m_acc_re[k] = 0; m_acc_im[k] = 0; m_cnt[k] = 0;
                exp_r[k] = 0; exp_im[k] = 0; exp_ovf[k] = 0; exp_vld[k] = 0;
            end
            model_ok = 1;
        end else begin
            for (int k = 0; k < 4; k++) exp_vld[k] = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                cur = q.pop_front();
                for (int k = 0; k < 4; k++) begin
                    m_acc_re[k] = (m_cnt[k] == 0) ? cur.re : m_acc_re[k] + cur.re;
                    m_acc_im[k] = (m_cnt[k] == 0) ? cur.im : m_acc_im[k] + cur.im;
                    if (cur.last || m_cnt[k] == acc_len(k) - 1) begin
                        exp_r[k]   = narrow_m(k, m_acc_re[k], ov_r);
                        exp_im[k]  = narrow_m(k, m_acc_im[k], ov_i);
                        exp_ovf[k] = ov_r | ov_i;
                        exp_vld[k] = 1;
                        m_cnt[k]   = 0;
                    end else begin
                        m_cnt[k]++;
                    end
                end
            end
            if (vld) begin
                ia = int'(a); ib = int'(b); ic = int'(c); id = int'(d);
                cur.re   = conj ? ia * ic + ib * id : ia * ic - ib * id;
                cur.im   = conj ? ib * ic - ia * id : ia * id + ib * ic;
                cur.last = last;
                cur.due  = cyc + 3;
                q.push_back(cur);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("model_vld%0d", k), int'(o_vld[k]), int'(exp_vld[k]));
                chk($sformatf("model_r%0d", k),   int'(o_r[k]),   exp_r[k]);
                chk($sformatf("model_im%0d", k),  int'(o_im[k]),  exp_im[k]);
                chk($sformatf("model_ovf%0d", k), int'(o_ovf[k]), int'(exp_ovf[k]));
            end
        end
    end

    // Pulse recorder for the literal expectations.
    int pulses    [4];
    int first_r   [4];
    int first_cyc [4];
    int last_r    [4];
    int last_im   [4];
    int last_ovf  [4];

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (o_vld[k] === 1'b1) begin
                pulses[k]++;
                if (pulses[k] == 1) begin
                    first_r[k]   = int'(o_r[k]);
                    first_cyc[k] = cyc;
                end
                last_r[k]   = int'(o_r[k]);
                last_im[k]  = int'(o_im[k]);
                last_ovf[k] = int'(o_ovf[k]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic put(int ai, int bi, int ci, int di, bit cj, bit ls);
        @(negedge clk);
        a = 4'(ai); b = 4'(bi); c = 4'(ci); d = 4'(di);
        conj = cj; last = ls; vld = 1'b1;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            vld = 1'b0; last = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; vld = 1'b0; last = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pulses[k] = 0; first_r[k] = 0; first_cyc[k] = 0;
            last_r[k] = 0; last_im[k] = 0; last_ovf[k] = 0;
        end
    endtask

    task automatic expect_pulse(string name, int k, int n, int r, int im, int ovf);
        chk({name, "_count"}, pulses[k], n);
        chk({name, "_r"},     last_r[k], r);
        chk({name, "_im"},    last_im[k], im);
        chk({name, "_ovf"},   last_ovf[k], ovf);
    endtask

    int c0;

    initial begin
        rst = 1'b1; vld = 1'b0; conj = 1'b0; last = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        for (int k = 0; k < 4; k++) pulses[k] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_r%0d", k),   int'(o_r[k]), 0);
            chk($sformatf("reset_im%0d", k),  int'(o_im[k]), 0);
            chk($sformatf("reset_vld%0d", k), int'(o_vld[k]), 0);
            chk($sformatf("reset_ovf%0d", k), int'(o_ovf[k]), 0);
        end

        // Plain multiply, latency 3 edges after capture
        do_reset();
        put(3, 2, 1, -2, 1'b0, 1'b0);
        c0 = cyc;
        idle(6);
        expect_pulse("t1_mul", 1, 1, 7, -4, 0);
        chk("t1_latency", first_cyc[1], c0 + 4);
        expect_pulse("t6_shift_mul", 3, 1, 2, -1, 0);
        chk("t1_no_frame_yet", pulses[0], 0);

        // Conjugate form
        do_reset();
        put(3, 2, 1, -2, 1'b1, 1'b0);
        idle(6);
        expect_pulse("t1_conj", 1, 1, -1, 8, 0);
        expect_pulse("t6_shift_conj", 3, 1, 0, 2, 0);

        // Rounding of a negative value
        do_reset();
        put(-3, 0, 2, 0, 1'b0, 1'b0);
        idle(6);
        expect_pulse("t6_shift_neg", 3, 1, -1, 0, 0);

        // Four-sample frame, back to back
        do_reset();
        repeat (4) put(1, 0, 1, 0, 1'b0, 1'b0);
        idle(6);
        expect_pulse("t2_frame", 0, 1, 4, 0, 0);
        expect_pulse("t2_single", 1, 4, 1, 0, 0);

        // Saturation and wrap
        do_reset();
        repeat (4) put(-8, 0, -8, 0, 1'b0, 1'b0);
        idle(6);
        expect_pulse("t3_sat", 0, 1, 127, 0, 1);
        expect_pulse("t3_wrap", 2, 1, 0, 0, 1);
        expect_pulse("t3_single", 1, 4, 64, 0, 0);

        // Negative saturation, imaginary in range
        do_reset();
        repeat (4) put(-8, -8, 7, -8, 1'b0, 1'b0);
        idle(6);
        expect_pulse("t7_negsat", 0, 1, -128, 32, 1);
        expect_pulse("t7_negwrap", 2, 1, 32, 32, 1);

        // Early close on last, then a full frame
        do_reset();
        put(1, 0, 1, 0, 1'b0, 1'b0);
        put(1, 0, 1, 0, 1'b0, 1'b1);
        repeat (4) put(1, 0, 1, 0, 1'b0, 1'b0);
        idle(6);
        chk("t4_first_r", first_r[0], 2);
        expect_pulse("t4_after_last", 0, 2, 4, 0, 0);

        // last on the final sample of a full frame closes once
        do_reset();
        repeat (3) put(1, 0, 1, 0, 1'b0, 1'b0);
        put(1, 0, 1, 0, 1'b0, 1'b1);
        idle(6);
        expect_pulse("t4_last_on_full", 0, 1, 4, 0, 0);

        // Bubbles between samples
        do_reset();
        for (int i = 0; i < 4; i++) begin
            put(1, 0, 1, 0, 1'b0, 1'b0);
            idle(1);
        end
        idle(6);
        expect_pulse("t5_bubbles", 0, 1, 4, 0, 0);

        // Reset mid-frame discards the partial frame
        repeat (2) put(1, 0, 1, 0, 1'b0, 1'b0);
        do_reset();
        chk("t5_rst_r", int'(o_r[0]), 0);
        chk("t5_rst_vld", int'(o_vld[0]), 0);
        chk("t5_rst_ovf", int'(o_ovf[0]), 0);
        repeat (3) put(1, 0, 1, 0, 1'b0, 1'b0);
        idle(6);
        chk("t5_no_pulse_3", pulses[0], 0);
        put(1, 0, 1, 0, 1'b0, 1'b0);
        idle(6);
        expect_pulse("t5_after_rst", 0, 1, 4, 0, 0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
